// File: rtl/timer_controller.sv
// Timer controller: free-running 16-bit system counter (DIV), programmable
// timer (TIMA) with modulo reload (TMA) and control (TAC), delayed reload and
// a one-cycle timer interrupt request pulse.
//
// Ports:
//   iClock           - single clock, rising edge
//   iReset           - asynchronous, active-low reset
//   iMcuWe           - CPU register write strobe
//   iMcuRegSelect    - register select: 4 DIV, 5 TIMA, 6 TMA, 7 TAC
//   iMcuWriteData    - CPU write data
//   oMcuReadData     - combinational read of selected register, 8'hFF otherwise
//   oDiv/oTima/oTma  - current register values
//   oTac             - current TAC value (3 bits)
//   oTimerInterrupt  - registered one-cycle timer interrupt request
module timer_controller #(
    parameter int unsigned RELOAD_DELAY = 4
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iMcuWe,
    input  logic [3:0] iMcuRegSelect,
    input  logic [7:0] iMcuWriteData,
    output logic [7:0] oMcuReadData,
    output logic [7:0] oDiv,
    output logic [7:0] oTima,
    output logic [7:0] oTma,
    output logic [2:0] oTac,
    output logic       oTimerInterrupt
);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StReload
    } state_e;

    // Delay-counter value on the last DELAY cycle (RELOAD_DELAY-1 cycles spent in DELAY).
    localparam logic [2:0] DelayLast = (RELOAD_DELAY > 1) ? 3'(RELOAD_DELAY - 2) : 3'd0;

    logic [15:0] r_counter;
    logic [2:0]  r_tac;
    logic [7:0]  r_tma;
    logic [7:0]  r_tima;
    state_e      r_state;
    logic [2:0]  r_delay;
    logic        r_irq;
    logic        r_tick;

    logic        w_we_div;
    logic        w_we_tima;
    logic        w_we_tma;
    logic        w_we_tac;
    logic [15:0] w_counter_d;
    logic [2:0]  w_tac_d;
    logic        w_tap_d;
    logic        w_tick_d;
    logic        w_tick_fall;
    state_e      w_state_d;
    logic [2:0]  w_delay_d;
    logic [7:0]  w_tima_d;
    logic        w_irq_d;

    assign w_we_div  = iMcuWe && (iMcuRegSelect == 4'h4);
    assign w_we_tima = iMcuWe && (iMcuRegSelect == 4'h5);
    assign w_we_tma  = iMcuWe && (iMcuRegSelect == 4'h6);
    assign w_we_tac  = iMcuWe && (iMcuRegSelect == 4'h7);

    assign w_counter_d = w_we_div ? 16'h0000 : r_counter + 16'h0001;
    assign w_tac_d     = w_we_tac ? iMcuWriteData[2:0] : r_tac;

    always_comb begin
        w_tap_d = 1'b0;
        case (w_tac_d[1:0])
            2'b00:   w_tap_d = w_counter_d[9];
            2'b01:   w_tap_d = w_counter_d[3];
            2'b10:   w_tap_d = w_counter_d[5];
            default: w_tap_d = w_counter_d[7];
        endcase
    end

    // Tick is evaluated on the next-state counter/TAC so that a falling tick
    // (including one caused by a DIV or TAC write) bumps TIMA on the same
    // edge that produces it. r_tick therefore always holds the current tick.
    assign w_tick_d    = w_tac_d[2] & w_tap_d;
    assign w_tick_fall = r_tick & ~w_tick_d;

    always_comb begin
        w_state_d = r_state;
        w_delay_d = r_delay;
        w_tima_d  = r_tima;
        w_irq_d   = 1'b0;
        case (r_state)
            StIdle: begin
                // A CPU write beats a coincident tick; no overflow is seen.
                if (w_we_tima) begin
                    w_tima_d = iMcuWriteData;
                end else if (w_tick_fall) begin
                    if (r_tima == 8'hFF) begin
                        w_tima_d  = 8'h00;
                        w_delay_d = 3'd0;
                        w_state_d = (RELOAD_DELAY == 1) ? StReload : StDelay;
                    end else begin
                        w_tima_d = r_tima + 8'h01;
                    end
                end
            end
            StDelay: begin
                w_delay_d = r_delay + 3'd1;
                if (w_we_tima) begin
                    // CPU write cancels the pending reload and interrupt.
                    w_tima_d  = iMcuWriteData;
                    w_delay_d = 3'd0;
                    w_state_d = StIdle;
                end else begin
                    if (w_tick_fall) begin
                        w_tima_d = r_tima + 8'h01;
                    end
                    if (r_delay == DelayLast) begin
                        w_state_d = StReload;
                    end
                end
            end
            StReload: begin
                // TIMA writes are ignored here; a TMA write lands in TIMA directly.
                w_tima_d  = w_we_tma ? iMcuWriteData : r_tma;
                w_irq_d   = 1'b1;
                w_delay_d = 3'd0;
                w_state_d = StIdle;
            end
            default: begin
                w_delay_d = 3'd0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_counter <= 16'h0000;
            r_tac     <= 3'd0;
            r_tma     <= 8'h00;
            r_tima    <= 8'h00;
            r_state   <= StIdle;
            r_delay   <= 3'd0;
            r_irq     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_counter <= w_counter_d;
            r_tac     <= w_tac_d;
            r_tick    <= w_tick_d;
            r_tima    <= w_tima_d;
            r_state   <= w_state_d;
            r_delay   <= w_delay_d;
            r_irq     <= w_irq_d;
            if (w_we_tma) begin
                r_tma <= iMcuWriteData;
            end
        end
    end

    always_comb begin
        oMcuReadData = 8'hFF;
        case (iMcuRegSelect)
            4'h4:    oMcuReadData = r_counter[15:8];
            4'h5:    oMcuReadData = r_tima;
            4'h6:    oMcuReadData = r_tma;
            4'h7:    oMcuReadData = {5'b11111, r_tac};
            default: oMcuReadData = 8'hFF;
        endcase
    end

    assign oDiv            = r_counter[15:8];
    assign oTima           = r_tima;
    assign oTma            = r_tma;
    assign oTac            = r_tac;
    assign oTimerInterrupt = r_irq;

endmodule

// File: tb/tb_timer_controller.sv
// Directed testbench for timer_controller. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_timer_controller;

    logic       iClock;
    logic       iReset;
    logic       iMcuWe;
    logic [3:0] iMcuRegSelect;
    logic [7:0] iMcuWriteData;
    logic [7:0] oMcuReadData;
    logic [7:0] oDiv;
    logic [7:0] oTima;
    logic [7:0] oTma;
    logic [2:0] oTac;
    logic       oTimerInterrupt;

    int n_checks = 0;
    int n_fail   = 0;

    timer_controller #(
        .RELOAD_DELAY(4)
    ) dut (
        .iClock         (iClock),
        .iReset         (iReset),
        .iMcuWe         (iMcuWe),
        .iMcuRegSelect  (iMcuRegSelect),
        .iMcuWriteData  (iMcuWriteData),
        .oMcuReadData   (oMcuReadData),
        .oDiv           (oDiv),
        .oTima          (oTima),
        .oTma           (oTma),
        .oTac           (oTac),
        .oTimerInterrupt(oTimerInterrupt)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        iMcuWe        = 1'b0;
        iMcuRegSelect = 4'h0;
        iMcuWriteData = 8'h00;
        iReset        = 1'b0;
        repeat (2) @(negedge iClock);
        iReset = 1'b1;
    endtask

    task automatic mcu_write(input logic [3:0] sel, input logic [7:0] data);
        iMcuWe        = 1'b1;
        iMcuRegSelect = sel;
        iMcuWriteData = data;
        @(negedge iClock);
        iMcuWe        = 1'b0;
        iMcuRegSelect = 4'h0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] sel, input logic [7:0] exp);
        iMcuRegSelect = sel;
        #1;
        check_eq(tag, 16'(oMcuReadData), 16'(exp));
    endtask

    // Arms TMA=AB, TIMA=FF, TAC=101 and returns at the first cycle where TIMA
    // reads 00 (first DELAY cycle).
    task automatic setup_overflow(input string tag);
        bit found = 1'b0;
        mcu_write(4'h6, 8'hAB);
        mcu_write(4'h5, 8'hFF);
        mcu_write(4'h7, 8'h05);
        for (int i = 0; i < 40; i++) begin
            if (oTima == 8'h00) begin
                found = 1'b1;
                break;
            end
            @(negedge iClock);
        end
        check_eq(tag, 16'(found), 16'd1);
    endtask

    task automatic wait_tima_change(output int n);
        logic [7:0] prev;
        prev = oTima;
        n = 0;
        while (oTima == prev && n < 40) begin
            @(negedge iClock);
            n++;
        end
    endtask

    initial begin
        int  n;
        bit  seen;

        // Reset state.
        do_reset();
        check_eq("rst_div", 16'(oDiv), 16'h00);
        check_eq("rst_tima", 16'(oTima), 16'h00);
        check_eq("rst_tma", 16'(oTma), 16'h00);
        check_eq("rst_tac", 16'(oTac), 16'h0);
        check_eq("rst_irq", 16'(oTimerInterrupt), 16'h0);
        read_check("rst_rd_tac", 4'h7, 8'hF8);

        // Register write / read mux; only TAC[2:0] is kept.
        mcu_write(4'h6, 8'h3C);
        mcu_write(4'h7, 8'hFD);
        check_eq("tac_val", 16'(oTac), 16'h5);
        read_check("rd_tac", 4'h7, 8'hFD);
        read_check("rd_tma", 4'h6, 8'h3C);
        read_check("rd_tima", 4'h5, 8'h00);
        read_check("rd_div", 4'h4, 8'h00);
        read_check("rd_other", 4'h0, 8'hFF);
        read_check("rd_other2", 4'hA, 8'hFF);

        // Basic count with TAC=101: +1 every 16 cycles.
        do_reset();
        mcu_write(4'h7, 8'h05);
        wait_tima_change(n);
        check_eq("cnt_first", 16'(oTima), 16'h01);
        for (int k = 2; k <= 4; k++) begin
            wait_tima_change(n);
            check_eq("cnt_period", 16'(n), 16'd16);
            check_eq("cnt_val", 16'(oTima), 16'(k));
        end

        // Overflow: 00 for 4 cycles, then AB with a single-cycle pulse.
        do_reset();
        setup_overflow("ovf_seen");
        check_eq("ovf_d0_irq", 16'(oTimerInterrupt), 16'h0);
        for (int c = 1; c < 4; c++) begin
            @(negedge iClock);
            check_eq("ovf_hold_tima", 16'(oTima), 16'h00);
            check_eq("ovf_hold_irq", 16'(oTimerInterrupt), 16'h0);
        end
        @(negedge iClock);
        check_eq("ovf_reload_tima", 16'(oTima), 16'hAB);
        check_eq("ovf_reload_irq", 16'(oTimerInterrupt), 16'h1);
        @(negedge iClock);
        check_eq("ovf_after_irq", 16'(oTimerInterrupt), 16'h0);
        check_eq("ovf_after_tima", 16'(oTima), 16'hAB);

        // Cancel: TIMA write in second DELAY cycle.
        do_reset();
        setup_overflow("cancel_seen");
        @(negedge iClock);
        mcu_write(4'h5, 8'h33);
        check_eq("cancel_tima", 16'(oTima), 16'h33);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (oTimerInterrupt) seen = 1'b1;
            @(negedge iClock);
        end
        check_eq("cancel_no_irq", 16'(seen), 16'h0);
        check_eq("cancel_tima_hold", 16'(oTima), 16'h33);

        // TMA write in RELOAD cycle goes straight to TIMA.
        do_reset();
        setup_overflow("tmarl_seen");
        repeat (3) @(negedge iClock);
        mcu_write(4'h6, 8'h5C);
        check_eq("tmarl_tima", 16'(oTima), 16'h5C);
        check_eq("tmarl_tma", 16'(oTma), 16'h5C);
        check_eq("tmarl_irq", 16'(oTimerInterrupt), 16'h1);

        // TIMA write in RELOAD cycle is ignored.
        do_reset();
        setup_overflow("timarl_seen");
        repeat (3) @(negedge iClock);
        mcu_write(4'h5, 8'h77);
        check_eq("timarl_tima", 16'(oTima), 16'hAB);
        check_eq("timarl_irq", 16'(oTimerInterrupt), 16'h1);

        // DIV-write glitch: TAC=100 with counter[9]=1.
        do_reset();
        mcu_write(4'h7, 8'h04);
        seen = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (oDiv[1]) begin
                seen = 1'b1;
                break;
            end
            @(negedge iClock);
        end
        check_eq("div_bit9_seen", 16'(seen), 16'h1);
        check_eq("div_pre_tima", 16'(oTima), 16'h00);
        mcu_write(4'h4, 8'hA5);
        check_eq("div_clr", 16'(oDiv), 16'h00);
        check_eq("div_glitch_tima", 16'(oTima), 16'h01);

        // Async reset in the middle of DELAY.
        do_reset();
        setup_overflow("arst_seen");
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        check_eq("arst_tima", 16'(oTima), 16'h00);
        check_eq("arst_tma", 16'(oTma), 16'h00);
        check_eq("arst_tac", 16'(oTac), 16'h0);
        check_eq("arst_div", 16'(oDiv), 16'h00);
        check_eq("arst_irq", 16'(oTimerInterrupt), 16'h0);
        read_check("arst_rd_tac", 4'h7, 8'hF8);
        repeat (2) @(negedge iClock);
        iReset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge iClock);
            if (oTimerInterrupt) seen = 1'b1;
        end
        check_eq("arst_no_irq", 16'(seen), 16'h0);
        check_eq("arst_post_tima", 16'(oTima), 16'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
